atr_io_ctrl: RTL and testbench
==============================

ATR_IO_CTRL -- requirements
Module: atr_io_ctrl

Interface
REQ-001 Parameter: DELAY_W, default 12, width of the TX/RX transition delay counters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: serial_addr  input  7  register address from the serial bus.
REQ-006 Port: serial_data  input  32  register write data.
REQ-007 Port: serial_strobe  input  1  one-cycle write qualifier.
REQ-008 Port: tx_empty  input  1  high when the TX path has no samples to send.
REQ-009 Port: reg_0 .. reg_3  output  16 each  pin output values fed to the io pin tristate stage.
REQ-010 Port: atr_state  output  2  current state encoding: 0=RX_ACTIVE, 1=TX_DELAY, 2=TX_ACTIVE, 3=RX_DELAY.

Function
REQ-011 Per bank N (0..3), the block SHALL hold io_reg_N, atr_mask_N, atr_txval_N and atr_rxval_N, each 16 bits.
REQ-012 A write to FR_IO_N SHALL update io_reg_N as (io_reg_N & ~data[31:16]) | (data[15:0] & data[31:16]).
REQ-013 Writes to FR_ATR_MASK_N, FR_ATR_TXVAL_N and FR_ATR_RXVAL_N SHALL load data[15:0] in full.
REQ-014 Writes to FR_ATR_TX_DELAY and FR_ATR_RX_DELAY SHALL load data[DELAY_W-1:0] into tx_delay and rx_delay.
REQ-015 Writes to unlisted addresses, and cycles without serial_strobe, SHALL change nothing.
REQ-016 The block SHALL sample tx_empty each clock; there is no input synchronizer.
REQ-017 RX_ACTIVE, tx_empty low: go to TX_ACTIVE if tx_delay=0, else to TX_DELAY with counter=tx_delay-1.
REQ-018 TX_DELAY: tx_empty high returns to RX_ACTIVE next edge (abort); else counter=0 goes to TX_ACTIVE; else decrement.
REQ-019 TX_ACTIVE, tx_empty high: go to RX_ACTIVE if rx_delay=0, else to RX_DELAY with counter=rx_delay-1.
REQ-020 RX_DELAY: tx_empty low returns to TX_ACTIVE next edge; else counter=0 goes to RX_ACTIVE; else decrement.
REQ-021 tx_mode SHALL be 1 in TX_ACTIVE and RX_DELAY, and 0 in RX_ACTIVE and TX_DELAY.
REQ-022 reg_N SHALL be registered as (io_reg_N & ~atr_mask_N) | (atr_mask_N & (tx_mode ? atr_txval_N : atr_rxval_N)).
REQ-023 reg_N SHALL use the state and config values as they stood before the same edge, giving one cycle of latency.
REQ-024 A delay-register write during TX_DELAY or RX_DELAY SHALL NOT alter the running count; the new value applies on the next entry.
REQ-025 A write that coincides with a state transition SHALL have both effects visible in reg_N one cycle later.

Reset
REQ-026 While reset_n is low, all registers, counters and reg_0..reg_3 SHALL be 0, and state SHALL be RX_ACTIVE (atr_state=0).
REQ-027 Assertion mid-delay SHALL abort the delay immediately; after release the FSM SHALL start in RX_ACTIVE.
REQ-028 Reset release SHALL be synchronous to clock.

Configuration
REQ-029 Macro ATR_DELAY_EN defined: the delay registers, counters and the TX_DELAY/RX_DELAY states SHALL exist as specified above.
REQ-030 Macro ATR_DELAY_EN undefined: tx_delay and rx_delay SHALL be treated as 0, with writes ignored and the delay states unreachable.
REQ-031 Macro ATR_DELAY_EN undefined: transitions SHALL occur on the edge following the tx_empty change.

Verification
REQ-032 Masked write: FR_IO_0 data 0x00FF_00AA then 0x0F00_0555 -> reg_0=0x00AA, then 0x05AA.
REQ-033 ATR basic, delays 0: mask_1=0x00F0, txval_1=0x0030, rxval_1=0x00C0, io_reg_1=0x1234; tx_empty falls -> reg_1 goes 0x12C4 to 0x1234 within 2 cycles, and back on rise.
REQ-034 TX delay: tx_delay=5; tx_empty falls at edge k -> atr_state=1 for 5 cycles, =2 after edge k+5; reg shows txval after edge k+6.
REQ-035 Abort: tx_delay=10, tx_empty low for 3 cycles only -> state returns to RX_ACTIVE and reg_N never shows txval.
REQ-036 Reset mid-RX_DELAY: rx_delay=100, assert reset_n at count 50 -> all outputs 0 at once, state 0; a fresh config after release works normally.
REQ-037 Build without ATR_DELAY_EN: delay writes of 20 -> transitions still take 1 cycle; atr_state never reads 1 or 3.

Source files
------------

// File: rtl/atr_io_ctrl.sv
// ============================================================================
// atr_io_ctrl
// ----------------------------------------------------------------------------
// Automatic transmit/receive (ATR) controller for four 16-bit io pin banks.
// A serial register bus loads per-bank io values, ATR masks and the TX/RX
// override values. A small FSM follows tx_empty between the RX and TX sides,
// with optional programmable transition delays. For every bank the pin
// output is the io register with the masked bits replaced by the TX or RX
// override value, depending on which side the FSM is on.
//
// Optional feature macro: ATR_DELAY_EN
//   defined   : tx_delay / rx_delay registers exist and the TX_DELAY /
//               RX_DELAY states are used when a delay is non-zero.
//   undefined : both delays are constant 0, delay writes are ignored and the
//               FSM moves directly between RX_ACTIVE and TX_ACTIVE.
//
// Register map (serial_addr), N = bank 0..3:
//   0x00+N  FR_IO_N          io_reg_N <= (io & ~d[31:16]) | (d[15:0] & d[31:16])
//   0x04+N  FR_ATR_MASK_N    atr_mask_N  <= d[15:0]
//   0x08+N  FR_ATR_TXVAL_N   atr_txval_N <= d[15:0]
//   0x0C+N  FR_ATR_RXVAL_N   atr_rxval_N <= d[15:0]
//   0x10    FR_ATR_TX_DELAY  tx_delay    <= d[DELAY_W-1:0]
//   0x11    FR_ATR_RX_DELAY  rx_delay    <= d[DELAY_W-1:0]
//   any other address is ignored.
//
// Ports:
//   clock          in   1   sole clock, rising edge
//   reset_n        in   1   asynchronous active-low reset (release is
//                           expected to be synchronous to clock)
//   serial_addr    in   7   register address
//   serial_data    in  32   register write data
//   serial_strobe  in   1   one-cycle write qualifier
//   tx_empty       in   1   high when the TX path has nothing to send
//   reg_0..reg_3   out 16   registered pin output values per bank
//   atr_state      out  2   0=RX_ACTIVE 1=TX_DELAY 2=TX_ACTIVE 3=RX_DELAY
// ============================================================================
module atr_io_ctrl #(
    parameter int DELAY_W = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        tx_empty,
    output logic [15:0] reg_0,
    output logic [15:0] reg_1,
    output logic [15:0] reg_2,
    output logic [15:0] reg_3,
    output logic [1:0]  atr_state
);

    // state      | meaning
    // RX_ACTIVE  | receive side; outputs use atr_rxval
    // TX_DELAY   | counting down before TX; outputs still use atr_rxval
    // TX_ACTIVE  | transmit side; outputs use atr_txval
    // RX_DELAY   | counting down before RX; outputs still use atr_txval
    typedef enum logic [1:0] {
        RX_ACTIVE = 2'd0,
        TX_DELAY  = 2'd1,
        TX_ACTIVE = 2'd2,
        RX_DELAY  = 2'd3
    } state_t;

    localparam logic [6:0] FR_ATR_TX_DELAY = 7'h10;
    localparam logic [6:0] FR_ATR_RX_DELAY = 7'h11;

    logic [15:0] r_io    [4];
    logic [15:0] r_mask  [4];
    logic [15:0] r_txval [4];
    logic [15:0] r_rxval [4];
    logic [15:0] r_out   [4];

    state_t               r_state;
    logic [DELAY_W-1:0]   r_count;

    logic [DELAY_W-1:0]   w_tx_delay;
    logic [DELAY_W-1:0]   w_rx_delay;
    logic                 w_bank_wr;
    logic [1:0]           w_group;
    logic [1:0]           w_bank;
    logic                 w_tx_mode;

    // Bank registers occupy 0x00..0x0F: addr[3:2] selects the register kind,
    // addr[1:0] selects the bank.
    assign w_bank_wr = serial_strobe && (serial_addr[6:4] == 3'b000);
    assign w_group   = serial_addr[3:2];
    assign w_bank    = serial_addr[1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_io[i]    <= '0;
                r_mask[i]  <= '0;
                r_txval[i] <= '0;
                r_rxval[i] <= '0;
            end
        end else if (w_bank_wr) begin
            case (w_group)
                2'd0: r_io[w_bank] <= (r_io[w_bank] & ~serial_data[31:16])
                                    | (serial_data[15:0] & serial_data[31:16]);
                2'd1: r_mask[w_bank]  <= serial_data[15:0];
                2'd2: r_txval[w_bank] <= serial_data[15:0];
                default: r_rxval[w_bank] <= serial_data[15:0];
            endcase
        end
    end

`ifdef ATR_DELAY_EN
    logic [DELAY_W-1:0] r_tx_delay;
    logic [DELAY_W-1:0] r_rx_delay;

    // The FSM samples these only when entering a delay state, so a write
    // while counting takes effect on the next entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_delay <= '0;
            r_rx_delay <= '0;
        end else if (serial_strobe) begin
            if (serial_addr == FR_ATR_TX_DELAY)
                r_tx_delay <= serial_data[DELAY_W-1:0];
            if (serial_addr == FR_ATR_RX_DELAY)
                r_rx_delay <= serial_data[DELAY_W-1:0];
        end
    end

    assign w_tx_delay = r_tx_delay;
    assign w_rx_delay = r_rx_delay;
`else
    // Zero delays make TX_DELAY and RX_DELAY unreachable.
    assign w_tx_delay = '0;
    assign w_rx_delay = '0;
`endif

    assign w_tx_mode = (r_state == TX_ACTIVE) || (r_state == RX_DELAY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RX_ACTIVE;
            r_count <= '0;
            for (int i = 0; i < 4; i++)
                r_out[i] <= '0;
        end else begin
            case (r_state)
                RX_ACTIVE: begin
                    if (!tx_empty) begin
                        if (w_tx_delay == '0) begin
                            r_state <= TX_ACTIVE;
                        end else begin
                            r_state <= TX_DELAY;
                            r_count <= w_tx_delay - DELAY_W'(1);
                        end
                    end
                end
                TX_DELAY: begin
                    if (tx_empty)
                        r_state <= RX_ACTIVE;
                    else if (r_count == '0)
                        r_state <= TX_ACTIVE;
                    else
                        r_count <= r_count - DELAY_W'(1);
                end
                TX_ACTIVE: begin
                    if (tx_empty) begin
                        if (w_rx_delay == '0) begin
                            r_state <= RX_ACTIVE;
                        end else begin
                            r_state <= RX_DELAY;
                            r_count <= w_rx_delay - DELAY_W'(1);
                        end
                    end
                end
                default: begin
                    if (!tx_empty)
                        r_state <= TX_ACTIVE;
                    else if (r_count == '0)
                        r_state <= RX_ACTIVE;
                    else
                        r_count <= r_count - DELAY_W'(1);
                end
            endcase

            // Built from pre-edge state and config, so a config write and a
            // state change on the same edge both show up one cycle later.
            for (int i = 0; i < 4; i++)
                r_out[i] <= (r_io[i] & ~r_mask[i])
                          | (r_mask[i] & (w_tx_mode ? r_txval[i] : r_rxval[i]));
        end
    end

    assign reg_0     = r_out[0];
    assign reg_1     = r_out[1];
    assign reg_2     = r_out[2];
    assign reg_3     = r_out[3];
    assign atr_state = r_state;

endmodule

// File: tb/tb_atr_io_ctrl.sv
module tb_atr_io_ctrl;

    localparam int DW = 12;

    logic        clock;
    logic        reset_n;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        tx_empty;
    logic [15:0] reg_0, reg_1, reg_2, reg_3;
    logic [1:0]  atr_state;

    int checks = 0;
    int errors = 0;

    atr_io_ctrl #(.DELAY_W(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .tx_empty      (tx_empty),
        .reg_0         (reg_0),
        .reg_1         (reg_1),
        .reg_2         (reg_2),
        .reg_3         (reg_3),
        .atr_state     (atr_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] dut_reg [4];
    assign dut_reg[0] = reg_0;
    assign dut_reg[1] = reg_1;
    assign dut_reg[2] = reg_2;
    assign dut_reg[3] = reg_3;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: which side the ATR is heading for (m_dir) and how
    // many more edges remain before it settles there (m_left).
    // ------------------------------------------------------------------
    logic [15:0] m_io [4], m_mask [4], m_tx [4], m_rx [4];
    logic [15:0] exp_reg [4];
    logic [1:0]  exp_state;
    int          m_txd, m_rxd, m_left;
    bit          m_dir;

    always @(posedge clock or negedge reset_n) begin
        bit txm;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_io[i] = 0; m_mask[i] = 0; m_tx[i] = 0; m_rx[i] = 0; exp_reg[i] = 0;
            end
            m_txd = 0; m_rxd = 0; m_left = 0; m_dir = 0;
        end else begin
            txm = (m_dir && m_left == 0) || (!m_dir && m_left != 0);
            for (int i = 0; i < 4; i++)
                exp_reg[i] = (m_io[i] & ~m_mask[i]) | (m_mask[i] & (txm ? m_tx[i] : m_rx[i]));

            if (!m_dir && m_left == 0) begin
                if (!tx_empty) begin m_dir = 1; m_left = m_txd; end
            end else if (m_dir && m_left > 0) begin
                if (tx_empty) begin m_dir = 0; m_left = 0; end
                else m_left--;
            end else if (m_dir) begin
                if (tx_empty) begin m_dir = 0; m_left = m_rxd; end
            end else begin
                if (!tx_empty) begin m_dir = 1; m_left = 0; end
                else m_left--;
            end

            if (serial_strobe) begin
                int a;
                a = int'(serial_addr);
                if (a < 4)
                    m_io[a] = (m_io[a] & ~serial_data[31:16]) | (serial_data[15:0] & serial_data[31:16]);
                else if (a < 8)  m_mask[a - 4] = serial_data[15:0];
                else if (a < 12) m_tx[a - 8]   = serial_data[15:0];
                else if (a < 16) m_rx[a - 12]  = serial_data[15:0];
`ifdef ATR_DELAY_EN
                else if (a == 16) m_txd = int'(serial_data % (1 << DW));
                else if (a == 17) m_rxd = int'(serial_data % (1 << DW));
`endif
            end
        end
        if (m_dir) exp_state = (m_left > 0) ? 2'd1 : 2'd2;
        else       exp_state = (m_left > 0) ? 2'd3 : 2'd0;
    end

    always @(posedge clock) begin
        #3;
        chk("state_vs_model", 16'(atr_state), 16'(exp_state));
        for (int i = 0; i < 4; i++)
            chk($sformatf("reg_%0d_vs_model", i), dut_reg[i], exp_reg[i]);
    end

    // Called at a negedge; returns at the following negedge.
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_addr = a; serial_data = d; serial_strobe = 1'b1;
        @(negedge clock);
        serial_strobe = 1'b0;
    endtask

    task automatic step;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; serial_addr = '0; serial_data = '0;
        serial_strobe = 1'b0; tx_empty = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_state", 16'(atr_state), 16'd0);
        chk("rst_reg0", reg_0, 16'h0000);
        chk("rst_reg3", reg_3, 16'h0000);
        reset_n = 1'b1;

        // masked io writes
        wr(7'h00, 32'h00FF_00AA); step;
        chk("io0_first", reg_0, 16'h00AA);
        wr(7'h00, 32'h0F00_0555); step;
        chk("io0_second", reg_0, 16'h05AA);
        wr(7'h48, 32'hFFFF_FFFF);
        wr(7'h12, 32'hFFFF_FFFF);
        serial_addr = 7'h00; serial_data = 32'hFFFF_0000; step; step;
        chk("io0_untouched", reg_0, 16'h05AA);

        // ATR config, delays 0
        wr(7'h05, 32'h0000_00F0);
        wr(7'h09, 32'h0000_0030);
        wr(7'h0D, 32'h0000_00C0);
        wr(7'h01, 32'hFFFF_1234);
        wr(7'h07, 32'h0000_FFFF);
        wr(7'h0B, 32'h0000_A5A5);
        wr(7'h0F, 32'h0000_5A5A);
        step;
        chk("atr_rx_reg1", reg_1, 16'h12C4);
        chk("atr_rx_reg3", reg_3, 16'h5A5A);
        tx_empty = 1'b0; step;
        chk("atr_tx_state", 16'(atr_state), 16'd2);
        chk("atr_tx_lat", reg_1, 16'h12C4);
        step;
        chk("atr_tx_reg1", reg_1, 16'h1234);
        chk("atr_tx_reg3", reg_3, 16'hA5A5);
        tx_empty = 1'b1; step;
        chk("atr_back_state", 16'(atr_state), 16'd0);
        step;
        chk("atr_back_reg1", reg_1, 16'h12C4);

`ifdef ATR_DELAY_EN
        // tx delay of 5
        wr(7'h10, 32'd5);
        tx_empty = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step;
            chk($sformatf("txd_state_%0d", c), 16'(atr_state), 16'd1);
            chk($sformatf("txd_reg1_%0d", c), reg_1, 16'h12C4);
        end
        step;
        chk("txd_active", 16'(atr_state), 16'd2);
        chk("txd_reg_lat", reg_1, 16'h12C4);
        step;
        chk("txd_reg_tx", reg_1, 16'h1234);
        tx_empty = 1'b1; step; step;

        // abort after 3 low cycles; a delay write while counting
        wr(7'h10, 32'd10);
        tx_empty = 1'b0;
        step; chk("abort_s1", 16'(atr_state), 16'd1); chk("abort_r1", reg_1, 16'h12C4);
        step; chk("abort_s2", 16'(atr_state), 16'd1); chk("abort_r2", reg_1, 16'h12C4);
        wr(7'h10, 32'd2);
        chk("abort_s3", 16'(atr_state), 16'd1); chk("abort_r3", reg_1, 16'h12C4);
        tx_empty = 1'b1;
        step; chk("abort_back", 16'(atr_state), 16'd0); chk("abort_r4", reg_1, 16'h12C4);
        step; chk("abort_r5", reg_1, 16'h12C4);
        tx_empty = 1'b0;
        step; chk("newd_s1", 16'(atr_state), 16'd1);
        step; chk("newd_s2", 16'(atr_state), 16'd1);
        step; chk("newd_s3", 16'(atr_state), 16'd2);
        tx_empty = 1'b1; step; step;

        // reset in the middle of a 100-cycle rx delay
        wr(7'h10, 32'd0);
        wr(7'h11, 32'd100);
        tx_empty = 1'b0; step;
        chk("rxd_tx", 16'(atr_state), 16'd2);
        tx_empty = 1'b1; step;
        chk("rxd_enter", 16'(atr_state), 16'd3);
        repeat (49) step;
        chk("rxd_mid", 16'(atr_state), 16'd3);
        chk("rxd_mid_reg1", reg_1, 16'h1234);
        reset_n = 1'b0; #1;
        chk("rst_mid_state", 16'(atr_state), 16'd0);
        chk("rst_mid_reg1", reg_1, 16'h0000);
        chk("rst_mid_reg3", reg_3, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        wr(7'h02, 32'hFFFF_ABCD); step;
        chk("fresh_io2", reg_2, 16'hABCD);
        chk("fresh_reg1", reg_1, 16'h0000);
        wr(7'h06, 32'h0000_00FF);
        wr(7'h0A, 32'h0000_0011);
        wr(7'h0E, 32'h0000_0022);
        wr(7'h10, 32'd1);
        step;
        chk("fresh_rx2", reg_2, 16'hAB22);
        tx_empty = 1'b0;
        step; chk("fresh_s1", 16'(atr_state), 16'd1);
        step; chk("fresh_s2", 16'(atr_state), 16'd2);
        step; chk("fresh_tx2", reg_2, 16'hAB11);
        tx_empty = 1'b1; step; step;
`else
        // delay writes are ignored: transitions still take one edge
        wr(7'h10, 32'd20);
        wr(7'h11, 32'd20);
        tx_empty = 1'b0; step;
        chk("nodly_tx", 16'(atr_state), 16'd2);
        step; chk("nodly_tx_reg1", reg_1, 16'h1234);
        tx_empty = 1'b1; step;
        chk("nodly_rx", 16'(atr_state), 16'd0);
        step; chk("nodly_rx_reg1", reg_1, 16'h12C4);
        tx_empty = 1'b0; step;
        chk("nodly_tx2", 16'(atr_state), 16'd2);
        reset_n = 1'b0; #1;
        chk("rst_mid_state", 16'(atr_state), 16'd0);
        chk("rst_mid_reg1", reg_1, 16'h0000);
        @(negedge clock);
        tx_empty = 1'b1;
        reset_n = 1'b1;
        wr(7'h02, 32'hFFFF_ABCD); step;
        chk("fresh_io2", reg_2, 16'hABCD);
        chk("fresh_reg1", reg_1, 16'h0000);
`endif
        repeat (3) step;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
